queue_ctrl_7x65: RTL and testbench

Pointer and handshake controller for a 7-entry, 65-bit ready/valid queue whose storage is an external `ram_data_7x65` array (one combinational read port, one clocked write port). The block accepts entries on an enqueue interface and presents them in FIFO order on a dequeue interface. It drives the array's W0 port on every accepted enqueue and its R0 port with the head pointer. It instantiates in the same clusters as the array, as the writer and reader of that memory.

---
 rtl/queue_ctrl_7x65.sv | 99 +++++++++
 tb/tb_queue_ctrl_7x65.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/queue_ctrl_7x65.sv
// Pointer and handshake controller for a DEPTH-entry ready/valid queue whose
// storage lives in an external array with a combinational read port (R0) and
// a clocked write port (W0). This block owns the pointers, the full/empty
// disambiguation bit and the occupancy count; the array owns the data.
module queue_ctrl_7x65 #(
  parameter int DEPTH = 7,
  parameter int WIDTH = 65,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  // Enqueue side
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_bits,
  // Dequeue side
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_bits,
  // Occupancy
  output logic [AW:0]      count,
  // Array read port
  output logic [AW-1:0]    R0_addr,
  output logic             R0_en,
  output logic             R0_clk,
  input  logic [WIDTH-1:0] R0_data,
  // Array write port
  output logic [AW-1:0]    W0_addr,
  output logic             W0_en,
  output logic             W0_clk,
  output logic [WIDTH-1:0] W0_data
);

  logic [AW-1:0] enq_ptr;
  logic [AW-1:0] deq_ptr;
  logic          maybe_full;
  logic [AW:0]   count_q;

  logic ptr_match;
  logic empty;
  logic full;
  logic enq_fire;
  logic deq_fire;

  // Advance a pointer by one slot. DEPTH need not be a power of two, so the
  // wrap from DEPTH-1 back to 0 is explicit rather than a natural overflow.
  function automatic logic [AW-1:0] bump(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
  endfunction

  // Equal pointers mean either empty or full; maybe_full tells them apart.
  assign ptr_match = (enq_ptr == deq_ptr);
  assign empty     = ptr_match & ~maybe_full;
  assign full      = ptr_match &  maybe_full;

  // Plain handshakes: no flow-through and no pipe mode, so enq_ready depends
  // only on full and deq_valid only on empty.
  assign enq_ready = ~full;
  assign deq_valid = ~empty;
  assign enq_fire  = enq_valid & enq_ready;
  assign deq_fire  = deq_valid & deq_ready;

  // Array ports. The write lands on the same edge that advances enq_ptr; the
  // read is combinational from the head pointer.
  assign W0_addr   = enq_ptr;
  assign W0_en     = enq_fire;
  assign W0_clk    = clock;
  assign W0_data   = enq_bits;
  assign R0_addr   = deq_ptr;
  assign R0_en     = ~empty;
  assign R0_clk    = clock;
  assign deq_bits  = R0_data;
  assign count     = count_q;

  // Pointer, full-flag and occupancy registers; reset empties the queue
  // immediately without touching the array contents.
  // NOTE: the array itself is never cleared on reset; an empty queue never
  // presents stale data as valid, so clearing it would buy nothing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enq_ptr    <= '0;
      deq_ptr    <= '0;
      maybe_full <= 1'b0;
      count_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values of its neighbours, independent of statement order.
      if (enq_fire) enq_ptr <= bump(enq_ptr);
      if (deq_fire) deq_ptr <= bump(deq_ptr);
      if (enq_fire != deq_fire) maybe_full <= enq_fire;
      case ({enq_fire, deq_fire})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_queue_ctrl_7x65.sv
// Self-checking bench for queue_ctrl_7x65. The external array is modelled
// here as a plain memory; expected behaviour comes from a reference FIFO
// (a SystemVerilog queue) plus slot counters kept modulo DEPTH.
module tb_queue_ctrl_7x65;

  localparam int DEPTH = 7;
  localparam int WIDTH = 65;
  localparam int AW    = 3;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             enq_valid;
  logic             enq_ready;
  logic [WIDTH-1:0] enq_bits;
  logic             deq_valid;
  logic             deq_ready;
  logic [WIDTH-1:0] deq_bits;
  logic [AW:0]      count;
  logic [AW-1:0]    R0_addr;
  logic             R0_en;
  logic             R0_clk;
  logic [WIDTH-1:0] R0_data;
  logic [AW-1:0]    W0_addr;
  logic             W0_en;
  logic             W0_clk;
  logic [WIDTH-1:0] W0_data;

  queue_ctrl_7x65 #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
    .clock(clock), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_bits(enq_bits),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_bits(deq_bits),
    .count(count),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_clk(R0_clk), .R0_data(R0_data),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_clk(W0_clk), .W0_data(W0_data)
  );

  always #5 clock = ~clock;

  // External array: clocked write, combinational read.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge W0_clk) if (W0_en) mem[W0_addr] <= W0_data;
  assign R0_data = mem[R0_addr];

  // Reference model.
  logic [WIDTH-1:0] ref_q[$];
  int               exp_waddr;
  int               exp_raddr;

  int checks_total  = 0;
  int checks_passed = 0;

  // Clock one edge, updating the model with the fires the rules imply.
  task automatic tick();
    bit ef;
    bit df;
    ef = reset_n && enq_valid && (ref_q.size() < DEPTH);
    df = reset_n && deq_ready && (ref_q.size() > 0);
    @(posedge clock);
    if (df) begin
      void'(ref_q.pop_front());
      exp_raddr = (exp_raddr + 1) % DEPTH;
    end
    if (ef) begin
      ref_q.push_back(enq_bits);
      exp_waddr = (exp_waddr + 1) % DEPTH;
    end
    @(negedge clock);
  endtask

  task automatic drive(input bit ev, input bit dr, input logic [WIDTH-1:0] bits);
    enq_valid = ev;
    deq_ready = dr;
    enq_bits  = bits;
    #1;
  endtask

  function automatic logic [WIDTH-1:0] rand_bits();
    return WIDTH'({$urandom(), $urandom(), $urandom()});
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    drive(0, 0, '0);
    @(negedge clock);
    checks_total++;
    if (enq_ready !== 1'b1 || deq_valid !== 1'b0 || R0_en !== 1'b0 || W0_en !== 1'b0)
      $display("FAIL reset_outputs: enq_ready=%b deq_valid=%b R0_en=%b W0_en=%b required 1 0 0 0",
               enq_ready, deq_valid, R0_en, W0_en);
    else checks_passed++;
    checks_total++;
    if (count !== '0) $display("FAIL reset_count: got %0d required 0", count);
    else checks_passed++;
    ref_q.delete();
    exp_waddr = 0;
    exp_raddr = 0;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_fill();
    logic [WIDTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v = {1'b1, 32'(i + 1), 32'(i + 1)};
      drive(1, 0, v);
      checks_total++;
      if (W0_en !== 1'b1 || W0_addr !== AW'(i) || W0_data !== v)
        $display("FAIL fill_write[%0d]: W0_en=%b W0_addr=%0d required 1 %0d", i, W0_en, W0_addr, i);
      else checks_passed++;
      tick();
      checks_total++;
      if (count !== (AW+1)'(i + 1)) $display("FAIL fill_count[%0d]: got %0d required %0d", i, count, i + 1);
      else checks_passed++;
    end
    drive(1, 0, {WIDTH{1'b1}});
    checks_total++;
    if (enq_ready !== 1'b0 || W0_en !== 1'b0)
      $display("FAIL full_blocks_write: enq_ready=%b W0_en=%b required 0 0", enq_ready, W0_en);
    else checks_passed++;
    tick();
    checks_total++;
    if (count !== (AW+1)'(DEPTH)) $display("FAIL full_hold_count: got %0d required %0d", count, DEPTH);
    else checks_passed++;
  endtask

  task automatic test_drain();
    logic [WIDTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v = {1'b1, 32'(i + 1), 32'(i + 1)};
      drive(0, 1, '0);
      checks_total++;
      if (deq_valid !== 1'b1 || deq_bits !== v || R0_addr !== AW'(i))
        $display("FAIL drain_data[%0d]: valid=%b bits=%h addr=%0d required 1 %h %0d",
                 i, deq_valid, deq_bits, R0_addr, v, i);
      else checks_passed++;
      tick();
      if (i == 0) begin
        checks_total++;
        if (enq_ready !== 1'b1) $display("FAIL ready_after_full_deq: got %b required 1", enq_ready);
        else checks_passed++;
      end
    end
    drive(0, 1, '0);
    checks_total++;
    if (deq_valid !== 1'b0 || count !== '0)
      $display("FAIL drained_empty: deq_valid=%b count=%0d required 0 0", deq_valid, count);
    else checks_passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    int enq_wraps = 0;
    int deq_wraps = 0;
    bit w6;
    bit r6;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, rand_bits());
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, rand_bits());
      checks_total++;
      if (count !== (AW+1)'(3) || enq_ready !== 1'b1 || deq_valid !== 1'b1 || deq_bits !== ref_q[0])
        $display("FAIL b2b[%0d]: count=%0d bits=%h required 3 %h", i, count, deq_bits, ref_q[0]);
      else checks_passed++;
      w6 = (W0_addr == AW'(DEPTH - 1)) && W0_en;
      r6 = (R0_addr == AW'(DEPTH - 1)) && deq_valid;
      tick();
      if (w6 && W0_addr == '0) enq_wraps++;
      if (r6 && R0_addr == '0) deq_wraps++;
    end
    checks_total++;
    if (enq_wraps < 2 || deq_wraps < 2)
      $display("FAIL b2b_wraps: enq=%0d deq=%0d required >=2 each", enq_wraps, deq_wraps);
    else checks_passed++;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, '0);
      checks_total++;
      if (deq_bits !== ref_q[0]) $display("FAIL b2b_drain[%0d]: got %h required %h", i, deq_bits, ref_q[0]);
      else checks_passed++;
      tick();
    end
  endtask

  task automatic test_no_flow_through();
    logic [WIDTH-1:0] v;
    v = WIDTH'(64'hDEAD_BEEF);
    drive(1, 1, v);
    checks_total++;
    if (deq_valid !== 1'b0) $display("FAIL no_flow_through: deq_valid=%b required 0", deq_valid);
    else checks_passed++;
    tick();
    drive(0, 0, '0);
    checks_total++;
    if (deq_valid !== 1'b1 || deq_bits !== v)
      $display("FAIL enq_latency: valid=%b bits=%h required 1 %h", deq_valid, deq_bits, v);
    else checks_passed++;
    drive(0, 1, '0);
    tick();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, rand_bits());
      tick();
    end
    drive(0, 0, '0);
    checks_total++;
    if (count !== (AW+1)'(5)) $display("FAIL pre_reset_count: got %0d required 5", count);
    else checks_passed++;
    reset_n = 1'b0;
    #1;
    checks_total++;
    if (count !== '0 || deq_valid !== 1'b0 || enq_ready !== 1'b1)
      $display("FAIL async_reset: count=%0d deq_valid=%b enq_ready=%b required 0 0 1",
               count, deq_valid, enq_ready);
    else checks_passed++;
    ref_q.delete();
    exp_waddr = 0;
    exp_raddr = 0;
    @(negedge clock);
    reset_n = 1'b1;
    drive(1, 0, rand_bits());
    checks_total++;
    if (W0_en !== 1'b1 || W0_addr !== '0)
      $display("FAIL post_reset_addr: W0_en=%b W0_addr=%0d required 1 0", W0_en, W0_addr);
    else checks_passed++;
    tick();
  endtask

  task automatic test_random();
    bit ev;
    bit dr;
    int errs = 0;
    for (int i = 0; i < 10000; i++) begin
      // Alternate fill-biased and drain-biased phases to hit full and empty often.
      if ((i / 400) % 2 == 0) begin
        ev = ($urandom_range(0, 3) != 0);
        dr = ($urandom_range(0, 3) == 0);
      end else begin
        ev = ($urandom_range(0, 3) == 0);
        dr = ($urandom_range(0, 3) != 0);
      end
      drive(ev, dr, rand_bits());
      checks_total++;
      if (count !== (AW+1)'(ref_q.size())
          || enq_ready !== (ref_q.size() < DEPTH)
          || deq_valid !== (ref_q.size() > 0)
          || R0_en !== (ref_q.size() > 0)
          || W0_en !== (ev && ref_q.size() < DEPTH)
          || R0_addr !== AW'(exp_raddr)
          || (W0_en === 1'b1 && W0_addr !== AW'(exp_waddr))
          || (ref_q.size() > 0 && deq_bits !== ref_q[0])) begin
        if (errs < 10)
          $display("FAIL random[%0d]: count=%0d exp=%0d rdy=%b vld=%b wen=%b waddr=%0d/%0d raddr=%0d/%0d bits=%h",
                   i, count, ref_q.size(), enq_ready, deq_valid, W0_en, W0_addr, exp_waddr,
                   R0_addr, exp_raddr, deq_bits);
        errs++;
      end else checks_passed++;
      tick();
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    enq_bits  = '0;
    @(negedge clock);
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_no_flow_through();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, required finish before 2000000");
    $fatal(1, "timeout");
  end

endmodule
